// File: rtl/bnn_layer_sequencer.sv
// Sequences one XNOR-popcount binary neuron over every neuron of a fully connected
// BNN layer: buffer the input vector, stream weights, threshold, hand off packed bits.
//
// state     | meaning
// S_LOAD    | accepting input words into the vector buffer
// S_COMPUTE | issuing weight reads and accumulating per-neuron match counts
// S_DONE    | packed layer result presented on out_valid/out_bits
module bnn_layer_sequencer #(
  parameter int WORDS   = 4,
  parameter int NEURONS = 8,
  parameter int ACC_W   = $clog2(32*WORDS+1),
  parameter int AW      = (NEURONS*WORDS > 1) ? $clog2(NEURONS*WORDS) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic [ACC_W-1:0]   thresh,
  output logic               w_rd_en,
  output logic [AW-1:0]      w_addr,
  input  logic [31:0]        w_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_bits,
  output logic               busy
);

  localparam int WW  = (WORDS > 1)   ? $clog2(WORDS)   : 1;
  localparam int NNW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic [WW-1:0]  LAST_WORD   = WW'(WORDS-1);
  localparam logic [NNW-1:0] LAST_NEURON = NNW'(NEURONS-1);
  localparam logic [AW-1:0]  LAST_ADDR   = AW'(NEURONS*WORDS-1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]      vec_q [WORDS];
  logic [WW-1:0]    wcnt_q;
  logic [WW-1:0]    cons_word_q;
  logic [NNW-1:0]   cons_neuron_q;
  logic [ACC_W-1:0] thresh_q;
  logic [ACC_W-1:0] acc_q;
  logic             rd_vld_q;

  logic             accept;
  logic             last_word_in;
  logic             last_read;
  logic [31:0]      xnor_w;
  logic [5:0]       match;
  logic [ACC_W-1:0] sum;

  always_comb begin
    accept       = (state_q == S_LOAD) && in_valid;
    last_word_in = accept && (wcnt_q == LAST_WORD);
    last_read    = rd_vld_q && (cons_word_q == LAST_WORD) && (cons_neuron_q == LAST_NEURON);
    xnor_w       = ~(vec_q[cons_word_q] ^ w_data);
    match        = '0;
    for (int i = 0; i < 32; i++) begin
      match = match + 6'(xnor_w[i]);
    end
    sum = acc_q + ACC_W'(match);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    if (last_word_in) state_d = S_COMPUTE;
      S_COMPUTE: if (last_read)    state_d = S_DONE;
      S_DONE:    if (out_ready)    state_d = S_LOAD;
      default:                     state_d = S_LOAD;
    endcase
  end

  // Read strobe is registered, so w_data for a read lines up with rd_vld_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) vec_q[i] <= '0;
      wcnt_q        <= '0;
      cons_word_q   <= '0;
      cons_neuron_q <= '0;
      thresh_q      <= '0;
      acc_q         <= '0;
      rd_vld_q      <= 1'b0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      out_bits      <= '0;
    end else begin
      rd_vld_q <= w_rd_en;
      if (accept) begin
        vec_q[wcnt_q] <= in_data;
        if (wcnt_q == '0) thresh_q <= thresh;
        if (last_word_in) begin
          wcnt_q        <= '0;
          acc_q         <= '0;
          out_bits      <= '0;
          cons_word_q   <= '0;
          cons_neuron_q <= '0;
          w_rd_en       <= 1'b1;
          w_addr        <= '0;
        end else begin
          wcnt_q <= wcnt_q + 1'b1;
        end
      end
      if (w_rd_en) begin
        if (w_addr == LAST_ADDR) w_rd_en <= 1'b0;
        else                     w_addr  <= w_addr + 1'b1;
      end
      if (rd_vld_q) begin
        if (cons_word_q == LAST_WORD) begin
          out_bits[cons_neuron_q] <= (sum >= thresh_q);
          acc_q                   <= '0;
          cons_word_q             <= '0;
          cons_neuron_q           <= (cons_neuron_q == LAST_NEURON) ? '0 : cons_neuron_q + 1'b1;
        end else begin
          acc_q       <= sum;
          cons_word_q <= cons_word_q + 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_LOAD);

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer: synchronous weight memory model,
// randomized vectors and a direct XNOR-popcount reference of the layer.
module tb_bnn_layer_sequencer;
  localparam int WORDS = 4, NEURONS = 8, ACC_W = 8, AW = 5, NW = NEURONS*WORDS;

  logic clock, reset_n, in_valid, in_ready, w_rd_en, out_valid, out_ready, busy;
  logic [31:0] in_data, w_data;
  logic [ACC_W-1:0] thresh;
  logic [AW-1:0] w_addr;
  logic [NEURONS-1:0] out_bits;

  bnn_layer_sequencer #(.WORDS(WORDS), .NEURONS(NEURONS), .ACC_W(ACC_W), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .thresh(thresh), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .busy(busy));

  int n_total = 0, n_bad = 0;
  int cyc = 0, last_acc = 0, n_acc = 0, viol = 0;
  logic [31:0] wmem [NW];
  logic [31:0] cur_vec [WORDS];
  int cur_th;
  logic [AW-1:0] addr_q [$];
  logic [NEURONS-1:0] res_q [$];

  initial clock = 0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (w_rd_en) begin
      w_data <= wmem[w_addr];
      addr_q.push_back(w_addr);
    end
    if (reset_n && in_valid && in_ready) n_acc <= n_acc + 1;
    if (reset_n && busy && in_ready) viol <= viol + 1;
    if (reset_n && out_valid && out_ready) res_q.push_back(out_bits);
  end

  // Reference: per neuron, count matching bits over the whole vector, compare to threshold.
  function automatic logic [NEURONS-1:0] model_bits();
    logic [NEURONS-1:0] r;
    logic [31:0] x;
    int s;
    r = '0;
    for (int n = 0; n < NEURONS; n++) begin
      s = 0;
      for (int w = 0; w < WORDS; w++) begin
        x = ~(cur_vec[w] ^ wmem[n*WORDS+w]);
        s += $countones(x);
      end
      r[n] = (s >= cur_th);
    end
    return r;
  endfunction

  task automatic send_vector(input int max_gap);
    int guard;
    for (int w = 0; w < WORDS; w++) begin
      in_valid = 0;
      repeat ($urandom_range(0, max_gap)) begin @(posedge clock); #1; end
      in_valid = 1;
      in_data  = cur_vec[w];
      thresh   = (w == 0) ? ACC_W'(cur_th) : ACC_W'($urandom);
      guard = 0;
      while (!in_ready && guard < 200) begin @(posedge clock); #1; guard++; end
      if (guard >= 200) begin
        $display("FAIL send_timeout in_ready=%0b required=1", in_ready); n_bad++;
      end
      @(posedge clock); #1;
    end
    last_acc = cyc;
    in_valid = 0;
  endtask

  task automatic get_result(output logic [NEURONS-1:0] bits, output int lat);
    int guard = 0;
    while (!out_valid && guard < 200) begin @(posedge clock); #1; guard++; end
    if (!out_valid) begin
      $display("FAIL result_timeout out_valid=%0b required=1", out_valid); n_bad++;
    end
    lat = cyc - last_acc;
    bits = out_bits;
    out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; in_valid = 0; out_ready = 0; in_data = '0; thresh = '0;
    repeat (3) @(posedge clock); #1;
    n_total += 5;
    if (w_rd_en !== 1'b0)  begin $display("FAIL rst_w_rd_en got=%0b exp=0", w_rd_en); n_bad++; end
    if (w_addr !== '0)     begin $display("FAIL rst_w_addr got=%0h exp=0", w_addr); n_bad++; end
    if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got=%0b exp=0", out_valid); n_bad++; end
    if (out_bits !== '0)   begin $display("FAIL rst_out_bits got=%0h exp=0", out_bits); n_bad++; end
    if (busy !== 1'b0)     begin $display("FAIL rst_busy got=%0b exp=0", busy); n_bad++; end
    reset_n = 1;
    @(posedge clock); #1;
    n_total++;
    if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready got=%0b exp=1", in_ready); n_bad++; end
  endtask

  task automatic test_all_match();
    logic [NEURONS-1:0] b; int lat;
    for (int i = 0; i < NW; i++) wmem[i] = 32'hFFFF_FFFF;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = 32'hFFFF_FFFF;
    cur_th = 64;
    addr_q.delete();
    send_vector(0);
    get_result(b, lat);
    n_total += 3;
    if (b !== 8'hFF) begin $display("FAIL all_match_bits got=%0h exp=ff", b); n_bad++; end
    // out_valid at cycle T+NW+2, i.e. NW+1 edges after the accepting edge
    if (lat !== NW+1) begin $display("FAIL all_match_latency got=%0d exp=%0d", lat, NW+1); n_bad++; end
    if (addr_q.size() !== NW) begin $display("FAIL rd_count got=%0d exp=%0d", addr_q.size(), NW); n_bad++; end
    for (int i = 0; i < addr_q.size(); i++) begin
      n_total++;
      if (int'(addr_q[i]) !== i) begin $display("FAIL addr_seq[%0d] got=%0d exp=%0d", i, addr_q[i], i); n_bad++; end
    end
  endtask

  task automatic test_odd_even();
    logic [NEURONS-1:0] b; int lat;
    for (int i = 0; i < NW; i++) wmem[i] = ((i / WORDS) % 2 == 1) ? 32'h0 : 32'hFFFF_FFFF;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = 32'hFFFF_FFFF;
    cur_th = 64;
    send_vector(2);
    get_result(b, lat);
    n_total++;
    if (b !== 8'h55) begin $display("FAIL odd_even_bits got=%0h exp=55", b); n_bad++; end
  endtask

  task automatic test_thresh_boundary();
    int ths [4] = '{64, 65, 0, 129};
    logic [NEURONS-1:0] exps [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [NEURONS-1:0] b; int lat;
    for (int i = 0; i < NW; i++) wmem[i] = 32'hFFFF_FFFF;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = 32'hFFFF_0000;
    for (int k = 0; k < 4; k++) begin
      cur_th = ths[k];
      send_vector(1);
      get_result(b, lat);
      n_total++;
      if (b !== exps[k]) begin $display("FAIL thresh_%0d got=%0h exp=%0h", ths[k], b, exps[k]); n_bad++; end
    end
  endtask

  task automatic test_random();
    logic [NEURONS-1:0] b, e; int lat;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NW; i++) wmem[i] = $urandom;
      for (int w = 0; w < WORDS; w++) cur_vec[w] = $urandom;
      cur_th = $urandom_range(52, 76);
      e = model_bits();
      send_vector(3);
      get_result(b, lat);
      n_total++;
      if (b !== e) begin $display("FAIL random_%0d got=%0h exp=%0h", k, b, e); n_bad++; end
    end
  endtask

  task automatic test_backpressure();
    logic [NEURONS-1:0] b, e; int lat, acc0, guard;
    for (int i = 0; i < NW; i++) wmem[i] = $urandom;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = $urandom;
    cur_th = $urandom_range(56, 72);
    e = model_bits();
    send_vector(0);
    guard = 0;
    while (!out_valid && guard < 200) begin @(posedge clock); #1; guard++; end
    acc0 = n_acc;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = $urandom;
      @(posedge clock); #1;
      n_total += 3;
      if (out_valid !== 1'b1) begin $display("FAIL bp_out_valid[%0d] got=%0b exp=1", c, out_valid); n_bad++; end
      if (out_bits !== e)     begin $display("FAIL bp_out_bits[%0d] got=%0h exp=%0h", c, out_bits, e); n_bad++; end
      if (in_ready !== 1'b0)  begin $display("FAIL bp_in_ready[%0d] got=%0b exp=0", c, in_ready); n_bad++; end
    end
    in_valid = 0;
    n_total++;
    if (n_acc !== acc0) begin $display("FAIL bp_accepts got=%0d exp=%0d", n_acc, acc0); n_bad++; end
    out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
    n_total += 2;
    if (out_valid !== 1'b0) begin $display("FAIL bp_release_valid got=%0b exp=0", out_valid); n_bad++; end
    if (in_ready !== 1'b1)  begin $display("FAIL bp_release_ready got=%0b exp=1", in_ready); n_bad++; end
    for (int w = 0; w < WORDS; w++) cur_vec[w] = $urandom;
    e = model_bits();
    send_vector(1);
    get_result(b, lat);
    n_total++;
    if (b !== e) begin $display("FAIL bp_next_vector got=%0h exp=%0h", b, e); n_bad++; end
  endtask

  task automatic test_reset_abort();
    logic [NEURONS-1:0] b, e; int lat;
    for (int i = 0; i < NW; i++) wmem[i] = $urandom;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = $urandom;
    cur_th = 64;
    send_vector(0);
    repeat (9) @(posedge clock);
    #1;
    reset_n = 0;
    #1;
    n_total += 4;
    if (w_rd_en !== 1'b0)   begin $display("FAIL abort_w_rd_en got=%0b exp=0", w_rd_en); n_bad++; end
    if (out_valid !== 1'b0) begin $display("FAIL abort_out_valid got=%0b exp=0", out_valid); n_bad++; end
    if (out_bits !== '0)    begin $display("FAIL abort_out_bits got=%0h exp=0", out_bits); n_bad++; end
    if (busy !== 1'b0)      begin $display("FAIL abort_busy got=%0b exp=0", busy); n_bad++; end
    @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    for (int w = 0; w < WORDS; w++) cur_vec[w] = $urandom;
    cur_th = $urandom_range(56, 72);
    e = model_bits();
    send_vector(2);
    get_result(b, lat);
    n_total++;
    if (b !== e) begin $display("FAIL abort_recovery got=%0h exp=%0h", b, e); n_bad++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2*WORDS];
    int ths [2];
    int idx = 0, guard = 0, acc0;
    logic rdy;
    for (int i = 0; i < NW; i++) wmem[i] = (i / WORDS < 4) ? 32'hFFFF_FFFF : 32'h0;
    for (int w = 0; w < WORDS; w++) begin
      words[w] = $urandom;
      words[WORDS+w] = 32'hFFFF_FFFF;
    end
    ths[0] = 0; ths[1] = 64;
    res_q.delete();
    acc0 = n_acc;
    out_ready = 1;
    in_valid = 1;
    while (idx < 2*WORDS && guard < 400) begin
      in_data = words[idx];
      thresh = (idx % WORDS == 0) ? ACC_W'(ths[idx / WORDS]) : ACC_W'($urandom);
      rdy = in_ready;
      @(posedge clock); #1;
      if (rdy) idx++;
      guard++;
    end
    in_valid = 0;
    guard = 0;
    while (res_q.size() < 2 && guard < 200) begin @(posedge clock); #1; guard++; end
    out_ready = 0;
    n_total += 4;
    if (res_q.size() !== 2) begin
      $display("FAIL b2b_count got=%0d exp=2", res_q.size()); n_bad++;
    end else begin
      if (res_q[0] !== 8'hFF) begin $display("FAIL b2b_vec_a got=%0h exp=ff", res_q[0]); n_bad++; end
      if (res_q[1] !== 8'h0F) begin $display("FAIL b2b_vec_b got=%0h exp=0f", res_q[1]); n_bad++; end
    end
    if (n_acc - acc0 !== 2*WORDS) begin $display("FAIL b2b_accepts got=%0d exp=%0d", n_acc - acc0, 2*WORDS); n_bad++; end
    n_total++;
    if (viol !== 0) begin $display("FAIL busy_in_ready got=%0d exp=0", viol); n_bad++; end
  endtask

  initial begin
    w_data = '0;
    test_reset();
    test_all_match();
    test_odd_even();
    test_thresh_boundary();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
